// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
//   - forwarding select encodings (fwd_a / fwd_b)
//   - PC mux select encodings (pc_sel)
//   - sequencer state encoding (3-bit)
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'd0;  // operand from register file
  localparam logic [1:0] FWD_EX  = 2'd1;  // operand from EX result
  localparam logic [1:0] FWD_WB  = 2'd2;  // operand from MW result

  localparam logic [1:0] PCSEL_PLUS4 = 2'd0;
  localparam logic [1:0] PCSEL_TGT   = 2'd1;
  localparam logic [1:0] PCSEL_RST   = 2'd2;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_RUN     = 3'd1,
    ST_LDSTALL = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_MWAIT   = 3'd4
  } state_e;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational hit detection and forward select for one source operand.
// Ports:
//   rs, use_rs          - operand register index and "instruction reads it"
//   ex_valid, ex_rd,
//   ex_regwen           - writeback info of the EX-stage instruction
//   wb_rd, wb_regwen    - writeback info of the MW-stage instruction
//   ex_hit, wb_hit      - operand matches the EX / MW destination
//   fwd                 - FWD_REG / FWD_EX / FWD_WB (EX wins over MW)
module hazard_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       use_rs,
  input  logic       ex_valid,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwen,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwen,
  output logic       ex_hit,
  output logic       wb_hit,
  output logic [1:0] fwd
);

  // x0 is hardwired zero, so it never matches anything.
  assign ex_hit = use_rs && (rs != 5'd0) && ex_valid && ex_regwen && (ex_rd == rs);
  assign wb_hit = use_rs && (rs != 5'd0) && wb_regwen && (wb_rd == rs);

  always_comb begin
    fwd = FWD_REG;
    if (ex_hit) begin
      fwd = FWD_EX;
    end else if (wb_hit) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 3-stage (ID, EX, MW) RV32I core.
// Produces operand forwarding selects, stall/flush/bubble strobes and the
// PC mux select; sequences load-use latency, taken redirects and data-memory
// waits; counts bubble cycles for a perf CSR.
// Ports:
//   clk, rst                        - clock, async active-high reset
//   id_rs1/rs2, id_use_rs1/rs2      - ID operand usage
//   ex_valid, ex_rd, ex_regwen,
//   ex_is_load, ex_redirect         - EX instruction info
//   mem_req, mem_ready              - data-memory handshake: an access issued
//                                     with mem_req completes in the cycle
//                                     mem_ready is high; until then the pipe
//                                     is frozen
//   wb_rd, wb_regwen                - MW instruction writeback info
//   cnt_clr                         - synchronous clear of bubble_cnt
//   fwd_a, fwd_b                    - operand sources
//   stall_pc, stall_id, stall_ex,
//   bubble_ex, flush_id, pc_sel     - pipeline control
//   bubble_cnt                      - cycles with stall_pc or bubble_ex
//   dbg_state                       - current sequencer state
// Control outputs are combinational from state and inputs so that a hazard
// seen this cycle stalls this cycle; the state register is reset
// asynchronously, so reset values appear as soon as rst rises.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwen,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwen,
  input  logic             cnt_clr,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall_pc,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [1:0]       pc_sel,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] LD_INIT = 3'(LOAD_LAT - 1);

  state_e           state_q, state_d;
  logic [2:0]       ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic       a_ex_hit, a_wb_hit, b_ex_hit, b_wb_hit;
  logic [1:0] a_fwd_raw, b_fwd_raw;
  logic       load_hit;

  hazard_fwd_unit u_fwd_a (
    .rs        (id_rs1),
    .use_rs    (id_use_rs1),
    .ex_valid  (ex_valid),
    .ex_rd     (ex_rd),
    .ex_regwen (ex_regwen),
    .wb_rd     (wb_rd),
    .wb_regwen (wb_regwen),
    .ex_hit    (a_ex_hit),
    .wb_hit    (a_wb_hit),
    .fwd       (a_fwd_raw)
  );

  hazard_fwd_unit u_fwd_b (
    .rs        (id_rs2),
    .use_rs    (id_use_rs2),
    .ex_valid  (ex_valid),
    .ex_rd     (ex_rd),
    .ex_regwen (ex_regwen),
    .wb_rd     (wb_rd),
    .wb_regwen (wb_regwen),
    .ex_hit    (b_ex_hit),
    .wb_hit    (b_wb_hit),
    .fwd       (b_fwd_raw)
  );

  // MW hits only matter for the select, which the sub-unit already encodes.
  logic unused_wb_hits;
  assign unused_wb_hits = a_wb_hit ^ b_wb_hit;

  assign load_hit = ex_is_load && (a_ex_hit || b_ex_hit);

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    fwd_a     = a_fwd_raw;
    fwd_b     = b_fwd_raw;
    stall_pc  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    pc_sel    = PCSEL_PLUS4;

    case (state_q)
      ST_RESET: begin
        pc_sel    = PCSEL_RST;
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
        fwd_a     = FWD_REG;
        fwd_b     = FWD_REG;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        // A load result is not yet available in EX; don't forward garbage.
        if (a_ex_hit && ex_is_load) fwd_a = FWD_REG;
        if (b_ex_hit && ex_is_load) fwd_b = FWD_REG;

        if (mem_req && !mem_ready) begin
          stall_pc = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
          state_d  = ST_MWAIT;
        end else if (ex_redirect) begin
          // Redirect outranks load-use: the ID instruction is being killed.
          pc_sel   = PCSEL_TGT;
          flush_id = 1'b1;
          state_d  = ST_FLUSH;
        end else if (load_hit) begin
          stall_pc  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          ld_cnt_d  = LD_INIT;
          state_d   = (LOAD_LAT > 1) ? ST_LDSTALL : ST_RUN;
        end
      end

      ST_LDSTALL: begin
        stall_pc  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
        ld_cnt_d  = ld_cnt_q - 3'd1;
        // <= guards against a stray zero count locking the pipe.
        if (ld_cnt_q <= 3'd1) begin
          state_d = ST_RUN;
        end
      end

      ST_FLUSH: begin
        // Kill the stale instruction returned by the synchronous fetch.
        bubble_ex = 1'b1;
        flush_id  = 1'b1;
        state_d   = ST_RUN;
      end

      ST_MWAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
        end else begin
          stall_pc = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase

    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      bubble_cnt_d = '0;
    end else if ((stall_pc || bubble_ex) && (state_q != ST_RESET)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RESET;
      ld_cnt_q     <= 3'd0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign dbg_state  = state_q;

endmodule
